// File: rtl/pulse_timing_pkg.sv
// rtl/pulse_timing_pkg.sv - shared state type, default width and saturating increment
package pulse_timing_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

  localparam int unsigned CNT_W_DEFAULT = 16;

  // Saturating increment for counters up to 32 bits wide; max_v is the counter's all-ones value.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - pulse input synchronizer with history flop and edge strobes
module sync_edge_detect #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic pulse_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  // Shift the raw input through the synchronizer chain and keep one cycle of history.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pulse_i};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = level_o & ~hist_q;
  assign fall_o  = ~level_o & hist_q;

endmodule

// File: rtl/pulse_timing_monitor.sv
// rtl/pulse_timing_monitor.sv - measures high/low phase lengths of a pulse train, valid/ready output
module pulse_timing_monitor
  import pulse_timing_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEFAULT,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             pulse_in,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] low_cnt,
  output logic             high_sat,
  output logic             low_sat,
  output logic             dropped
);

  localparam logic [31:0]      CNT_MAX  = 32'((64'd1 << CNT_W) - 64'd1);
  localparam logic [CNT_W-1:0] CNT_ONES = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic level;
  logic rise;
  logic fall;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clock  (clock),
    .reset_n(reset_n),
    .pulse_i(pulse_in),
    .level_o(level),
    .rise_o (rise),
    .fall_o (fall)
  );

  state_e           state_q;
  logic [CNT_W-1:0] hc_q;
  logic [CNT_W-1:0] lc_q;
  logic             hs_q;
  logic             ls_q;

  logic [CNT_W-1:0] hc_inc;
  logic [CNT_W-1:0] lc_inc;
  logic             capture;

  assign hc_inc  = CNT_W'(sat_inc(32'(hc_q), CNT_MAX));
  assign lc_inc  = CNT_W'(sat_inc(32'(lc_q), CNT_MAX));
  // A rise seen while counting low closes one full rise-to-rise period.
  assign capture = enable & (state_q == LOW) & rise;

  // Phase tracking: counts cycles of each synchronized level; sat flags record a lost increment.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      hc_q    <= '0;
      lc_q    <= '0;
      hs_q    <= 1'b0;
      ls_q    <= 1'b0;
    end else if (!enable) begin
      state_q <= IDLE;
      hc_q    <= '0;
      lc_q    <= '0;
      hs_q    <= 1'b0;
      ls_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise) begin
            state_q <= HIGH;
            hc_q    <= CNT_ONE;
            lc_q    <= '0;
            hs_q    <= 1'b0;
            ls_q    <= 1'b0;
          end
        end
        HIGH: begin
          if (fall) begin
            state_q <= LOW;
            lc_q    <= CNT_ONE;
            ls_q    <= 1'b0;
          end else if (level) begin
            hc_q <= hc_inc;
            if (hc_q == CNT_ONES) hs_q <= 1'b1;
          end
        end
        LOW: begin
          if (rise) begin
            state_q <= HIGH;
            hc_q    <= CNT_ONE;
            lc_q    <= '0;
            hs_q    <= 1'b0;
            ls_q    <= 1'b0;
          end else if (!level) begin
            lc_q <= lc_inc;
            if (lc_q == CNT_ONES) ls_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  logic             meas_valid_q;
  logic [CNT_W-1:0] high_cnt_q;
  logic [CNT_W-1:0] low_cnt_q;
  logic             high_sat_q;
  logic             low_sat_q;
  logic             dropped_q;

  // Output holding register: loads on capture when free or draining, otherwise flags the loss.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meas_valid_q <= 1'b0;
      high_cnt_q   <= '0;
      low_cnt_q    <= '0;
      high_sat_q   <= 1'b0;
      low_sat_q    <= 1'b0;
      dropped_q    <= 1'b0;
    end else if (capture) begin
      if (!meas_valid_q || meas_ready) begin
        meas_valid_q <= 1'b1;
        high_cnt_q   <= hc_q;
        low_cnt_q    <= lc_q;
        high_sat_q   <= hs_q;
        low_sat_q    <= ls_q;
      end else begin
        dropped_q <= 1'b1;
      end
    end else if (meas_valid_q && meas_ready) begin
      meas_valid_q <= 1'b0;
    end
  end

  assign meas_valid = meas_valid_q;
  assign high_cnt   = high_cnt_q;
  assign low_cnt    = low_cnt_q;
  assign high_sat   = high_sat_q;
  assign low_sat    = low_sat_q;
  assign dropped    = dropped_q;

endmodule

// File: tb/tb_pulse_timing_monitor.sv
// tb/tb_pulse_timing_monitor.sv - directed self-checking bench for pulse_timing_monitor
module tb_pulse_timing_monitor;

  localparam int SYNC = 2;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b1;
  logic        pulse_in = 1'b0;
  logic        meas_ready = 1'b1;
  logic        meas_valid;
  logic [15:0] high_cnt;
  logic [15:0] low_cnt;
  logic        high_sat;
  logic        low_sat;
  logic        dropped;

  logic        pulse4 = 1'b0;
  logic        v4;
  logic [3:0]  hc4;
  logic [3:0]  lc4;
  logic        hs4;
  logic        ls4;
  logic        dr4;

  int checks = 0;
  int errors = 0;

  logic [33:0] q[$];
  logic [9:0]  q4[$];

  always #5 clock = ~clock;

  pulse_timing_monitor #(.CNT_W(16), .SYNC_STAGES(SYNC)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .enable    (enable),
    .pulse_in  (pulse_in),
    .meas_valid(meas_valid),
    .meas_ready(meas_ready),
    .high_cnt  (high_cnt),
    .low_cnt   (low_cnt),
    .high_sat  (high_sat),
    .low_sat   (low_sat),
    .dropped   (dropped)
  );

  pulse_timing_monitor #(.CNT_W(4), .SYNC_STAGES(SYNC)) dut4 (
    .clock     (clock),
    .reset_n   (reset_n),
    .enable    (1'b1),
    .pulse_in  (pulse4),
    .meas_valid(v4),
    .meas_ready(1'b1),
    .high_cnt  (hc4),
    .low_cnt   (lc4),
    .high_sat  (hs4),
    .low_sat   (ls4),
    .dropped   (dr4)
  );

  // Record every completed handshake, sampled midway between active edges.
  always @(negedge clock) begin
    if (reset_n && meas_valid && meas_ready) q.push_back({high_sat, low_sat, high_cnt, low_cnt});
    if (reset_n && v4) q4.push_back({hs4, ls4, hc4, lc4});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic seg(input logic lvl, input int n);
    pulse_in = lvl;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic seg4(input logic lvl, input int n);
    pulse4 = lvl;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    @(posedge clock);
    #1;
    q.delete();
    q4.delete();
  endtask

  task automatic expect_meas(input string tag, input int h, input int l, input bit hs, input bit ls);
    logic [33:0] m;
    check({tag, "_avail"}, 32'(q.size() != 0), 32'd1);
    if (q.size() != 0) begin
      m = q.pop_front();
      check({tag, "_high"}, 32'(m[31:16]), 32'(h));
      check({tag, "_low"}, 32'(m[15:0]), 32'(l));
      check({tag, "_hsat"}, 32'(m[33]), 32'(hs));
      check({tag, "_lsat"}, 32'(m[32]), 32'(ls));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired got timeout exp finish");
    $fatal(1);
  end

  initial begin
    int rise_k;
    int valid_k;
    logic [9:0] m4;

    // reset state
    repeat (2) @(posedge clock);
    #1;
    check("rst_valid", 32'(meas_valid), 32'd0);
    check("rst_high", 32'(high_cnt), 32'd0);
    check("rst_low", 32'(low_cnt), 32'd0);
    check("rst_dropped", 32'(dropped), 32'd0);
    do_reset();

    // 1: the 10/30/1/1 train with a free consumer
    seg(0, 5);
    repeat (2) begin
      seg(1, 10); seg(0, 30); seg(1, 1); seg(0, 1);
    end
    seg(1, 10); seg(0, 6);
    expect_meas("t1_m0", 10, 30, 0, 0);
    expect_meas("t1_m1", 1, 1, 0, 0);
    expect_meas("t1_m2", 10, 30, 0, 0);
    expect_meas("t1_m3", 1, 1, 0, 0);
    check("t1_extra", 32'(q.size()), 32'd0);
    check("t1_dropped", 32'(dropped), 32'd0);

    // 2: latency from input sample to rise and to meas_valid
    do_reset();
    seg(1, 3); seg(0, 6);
    pulse_in = 1'b1;
    rise_k = -1;
    valid_k = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (rise_k < 0 && dut.rise) rise_k = k;
      if (valid_k < 0 && meas_valid) valid_k = k;
    end
    @(posedge clock);
    #1;
    check("t2_rise_lat", 32'(rise_k), 32'(SYNC));
    check("t2_valid_lat", 32'(valid_k), 32'(SYNC + 1));
    seg(0, 4);
    expect_meas("t2_m0", 3, 6, 0, 0);

    // 3: backpressure across two periods, then drain
    do_reset();
    meas_ready = 1'b0;
    seg(0, 5); seg(1, 10); seg(0, 30); seg(1, 1); seg(0, 1); seg(1, 10); seg(0, 10);
    check("t3_hold_valid", 32'(meas_valid), 32'd1);
    check("t3_hold_high", 32'(high_cnt), 32'd10);
    check("t3_hold_low", 32'(low_cnt), 32'd30);
    check("t3_dropped", 32'(dropped), 32'd1);
    meas_ready = 1'b1;
    @(posedge clock);
    #1;
    check("t3_drained", 32'(meas_valid), 32'd0);
    seg(1, 5); seg(0, 5);
    expect_meas("t3_m0", 10, 30, 0, 0);
    expect_meas("t3_m1", 10, 11, 0, 0);
    check("t3_extra", 32'(q.size()), 32'd0);

    // 4: saturation on the 4-bit instance
    do_reset();
    seg4(0, 5); seg4(1, 20); seg4(0, 3); seg4(1, 2); seg4(0, 4);
    check("t4_avail", 32'(q4.size()), 32'd1);
    if (q4.size() != 0) begin
      m4 = q4.pop_front();
      check("t4_high", 32'(m4[7:4]), 32'd15);
      check("t4_low", 32'(m4[3:0]), 32'd3);
      check("t4_hsat", 32'(m4[9]), 32'd1);
      check("t4_lsat", 32'(m4[8]), 32'd0);
    end

    // 5: enable mid-high, then disable/re-enable mid-low
    enable = 1'b0;
    do_reset();
    seg(1, 4);
    enable = 1'b1;
    seg(1, 4); seg(0, 8); seg(1, 6); seg(0, 7); seg(1, 3); seg(0, 4);
    enable = 1'b0;
    seg(0, 4);
    enable = 1'b1;
    seg(0, 4); seg(1, 5); seg(0, 5); seg(1, 2); seg(0, 4);
    expect_meas("t5_m0", 6, 7, 0, 0);
    expect_meas("t5_m1", 5, 5, 0, 0);
    check("t5_extra", 32'(q.size()), 32'd0);

    // 6: asynchronous reset mid-high with a pending measurement
    meas_ready = 1'b0;
    do_reset();
    seg(0, 5); seg(1, 10); seg(0, 30); seg(1, 6);
    check("t6_pre_valid", 32'(meas_valid), 32'd1);
    #3;
    reset_n = 1'b0;
    pulse_in = 1'b0;
    #1;
    check("t6_rst_valid", 32'(meas_valid), 32'd0);
    check("t6_rst_high", 32'(high_cnt), 32'd0);
    check("t6_rst_low", 32'(low_cnt), 32'd0);
    check("t6_rst_dropped", 32'(dropped), 32'd0);
    meas_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    seg(0, 3); seg(1, 7); seg(0, 9); seg(1, 2); seg(0, 4);
    expect_meas("t6_m0", 7, 9, 0, 0);
    check("t6_extra", 32'(q.size()), 32'd0);
    check("t6_dropped", 32'(dropped), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
